// File: rtl/node_line_decoder_pkg.sv
// rtl/node_line_decoder_pkg.sv - aoc_node_pkg: node string type, ASCII constants, FSM states
package aoc_node_pkg;

  localparam int NODE_STR_W = 15;

  typedef logic [NODE_STR_W-1:0] node_str_t;

  localparam logic [7:0] A_CHAR = 8'h61;
  localparam logic [7:0] Z_CHAR = 8'h7A;
  localparam logic [7:0] COLON  = 8'h3A;
  localparam logic [7:0] SPACE  = 8'h20;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] NUL    = 8'h00;

  typedef enum logic [2:0] {
    S_SRC,
    S_COLON,
    S_DST,
    S_SKIP,
    S_DONE
  } dec_state_t;

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= A_CHAR) && (b <= Z_CHAR);
  endfunction

  function automatic logic [4:0] letter_code(input logic [7:0] b);
    logic [7:0] d;
    d = b - A_CHAR;
    return d[4:0];
  endfunction

  // c0 is the first character on the wire and lands in the low bits.
  function automatic node_str_t node_str_from_node_ascii(input logic [7:0] c0,
                                                         input logic [7:0] c1,
                                                         input logic [7:0] c2);
    return {letter_code(c2), letter_code(c1), letter_code(c0)};
  endfunction

endpackage

// File: rtl/node_line_decoder_if.sv
// rtl/node_line_decoder_if.sv - inbound ASCII byte stream into node_line_decoder
interface node_line_decoder_if;
  logic       inbound_valid;
  logic [7:0] inbound_data;

  modport master (output inbound_valid, output inbound_data);
  modport slave  (input  inbound_valid, input  inbound_data);
endinterface

// File: rtl/node_line_decoder.sv
// rtl/node_line_decoder.sv - "abc: def ghi\n" byte stream to node-string events; NODE_DECODER_STATS_EN adds line/edge counters
module node_line_decoder
  import aoc_node_pkg::*;
#(
  parameter int NODE_STR_WIDTH = 15
`ifdef NODE_DECODER_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  node_line_decoder_if.slave        in_if,
  output logic                      decoding_done_str,
  output logic                      src_node_str_valid,
  output logic                      edge_str_valid,
  output logic [NODE_STR_WIDTH-1:0] src_node_str,
  output logic [NODE_STR_WIDTH-1:0] dst_node_str,
  output logic                      parse_error
`ifdef NODE_DECODER_STATS_EN
  , output logic [CNT_WIDTH-1:0]    line_cnt
  , output logic [CNT_WIDTH-1:0]    edge_cnt
`endif
);

  dec_state_t                state_q;
  logic [1:0]                cnt_q;
  node_str_t                 sr_q;
  logic [NODE_STR_WIDTH-1:0] src_q;
  logic [NODE_STR_WIDTH-1:0] dst_q;
  logic                      src_vld_q;
  logic                      edge_vld_q;
  logic                      done_q;
  logic                      err_q;

  logic [7:0] byte_w;
  logic       accept;
  logic       is_letter;
  logic       bad;

  assign byte_w = in_if.inbound_data;
  assign accept = in_if.inbound_valid && (byte_w != CR) && (state_q != S_DONE);

  // bad: the byte is not a legal continuation of the current token in this state
  always_comb begin
    is_letter = is_lower(byte_w);
    bad       = 1'b0;
    case (state_q)
      S_SRC:   bad = !((is_letter && cnt_q != 2'd3) ||
                       (byte_w == COLON && cnt_q == 2'd3) ||
                       ((byte_w == LF || byte_w == NUL) && cnt_q == 2'd0));
      S_COLON: bad = (byte_w != SPACE);
      S_DST:   bad = !((is_letter && cnt_q != 2'd3) ||
                       ((byte_w == SPACE || byte_w == LF) && cnt_q == 2'd3) ||
                       ((byte_w == SPACE || byte_w == NUL) && cnt_q == 2'd0));
      default: bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SRC;
      cnt_q      <= 2'd0;
      sr_q       <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      src_vld_q  <= 1'b0;
      edge_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      src_vld_q  <= 1'b0;
      edge_vld_q <= 1'b0;
      if (accept) begin
        if (bad) begin
          err_q <= 1'b1;
          cnt_q <= 2'd0;
          // An offending LF already ends the line, so skipping would eat the next one.
          if (byte_w == NUL) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (byte_w == LF) begin
            state_q <= S_SRC;
          end else begin
            state_q <= S_SKIP;
          end
        end else begin
          case (state_q)
            S_SRC: begin
              if (is_letter) begin
                sr_q  <= {letter_code(byte_w), sr_q[NODE_STR_W-1:5]};
                cnt_q <= cnt_q + 2'd1;
              end else if (byte_w == COLON) begin
                src_q     <= sr_q;
                src_vld_q <= 1'b1;
                cnt_q     <= 2'd0;
                state_q   <= S_COLON;
              end else if (byte_w == NUL) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
            S_COLON: begin
              cnt_q   <= 2'd0;
              state_q <= S_DST;
            end
            S_DST: begin
              if (is_letter) begin
                sr_q  <= {letter_code(byte_w), sr_q[NODE_STR_W-1:5]};
                cnt_q <= cnt_q + 2'd1;
              end else if (cnt_q == 2'd3) begin
                dst_q      <= sr_q;
                edge_vld_q <= 1'b1;
                cnt_q      <= 2'd0;
                if (byte_w == LF) state_q <= S_SRC;
              end else if (byte_w == NUL) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
            S_SKIP: begin
              if (byte_w == LF) begin
                cnt_q   <= 2'd0;
                state_q <= S_SRC;
              end else if (byte_w == NUL) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign decoding_done_str  = done_q;
  assign src_node_str_valid = src_vld_q;
  assign edge_str_valid     = edge_vld_q;
  assign src_node_str       = src_q;
  assign dst_node_str       = dst_q;
  assign parse_error        = err_q;

`ifdef NODE_DECODER_STATS_EN
  logic [CNT_WIDTH-1:0] line_cnt_q;
  logic [CNT_WIDTH-1:0] edge_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_q <= '0;
      edge_cnt_q <= '0;
    end else begin
      if (src_vld_q && line_cnt_q != '1) line_cnt_q <= line_cnt_q + 1'b1;
      if (edge_vld_q && edge_cnt_q != '1) edge_cnt_q <= edge_cnt_q + 1'b1;
    end
  end

  assign line_cnt = line_cnt_q;
  assign edge_cnt = edge_cnt_q;
`endif

endmodule

// File: doc/node_line_decoder.md
Name: node_line_decoder

Overview:
- Upstream stage of node_id_mapper: turns the raw ASCII puzzle byte stream into 15-bit node-string events.
- Input lines have the form "abc: def ghi\n".
- Emits one src_node_str_valid pulse per line, then one edge_str_valid pulse per destination, then decoding_done_str after the terminating NUL.
- No backpressure: one byte is accepted every cycle inbound_valid is high.

Parameters:
- NODE_STR_WIDTH, 15, node string width (3 x 5-bit letters); do not override.
- CNT_WIDTH, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- inbound_valid  in  1  byte strobe.
- inbound_data  in  8  ASCII byte.
- decoding_done_str  out  1  level; high after the NUL terminator.
- src_node_str_valid  out  1  one-cycle pulse per line.
- edge_str_valid  out  1  one-cycle pulse per destination.
- src_node_str  out  15  current line's source; held stable until the next line's colon.
- dst_node_str  out  15  destination; valid with edge_str_valid.
- parse_error  out  1  sticky malformed-input flag.
- line_cnt  out  CNT_WIDTH  lines decoded (NODE_DECODER_STATS_EN only).
- edge_cnt  out  CNT_WIDTH  edges emitted (NODE_DECODER_STATS_EN only).

Behaviour:
- Encoding: str[4:0]=char0-'a', str[9:5]=char1-'a', str[14:10]=char2-'a'. Char0 is the first char on the wire.
- Reset: all outputs 0; FSM in S_SRC; char count 0; shift register 0. Reset mid-line discards the partial line, with no pulse afterwards.
- FSM states: S_SRC, S_COLON, S_DST, S_SKIP, S_DONE.
- S_SRC: accepts lowercase letters into the shift register. After exactly 3 letters, expects ':'.
  - ':' with count 3 -> next cycle src_node_str loaded and src_node_str_valid pulses (latency 1); go to S_COLON.
  - LF with count 0 (empty line) is ignored.
  - NUL with count 0 -> S_DONE.
- S_COLON: expects ' ' -> S_DST with count 0.
- S_DST: accepts letters.
  - ' ' or LF with count 3 -> next cycle dst_node_str loaded and edge_str_valid pulses.
  - After ' ' stay in S_DST; after LF go to S_SRC.
  - Further ' ' with count 0 is tolerated (repeated spaces).
- CR (0x0D) is ignored in every state.
- Any other byte, or a letter/terminator at the wrong count -> parse_error set (sticky until reset); go to S_SKIP; no pulse for the offending token.
- S_SKIP: drops bytes until LF -> S_SRC, or NUL -> S_DONE. Edges already emitted for the line stand.
- NUL in S_COLON or in S_DST mid-token: parse_error, then S_DONE.
- NUL in S_DST at count 0: S_DONE without error.
- S_DONE: decoding_done_str=1 from the cycle after NUL. All further bytes are ignored; only reset exits.
- src_node_str_valid and edge_str_valid are never high in the same cycle; at most one pulse per accepted byte.
- The src pulse always precedes that line's edge pulses. Consecutive edge pulses need no idle gap (e.g. single-char tokens cannot occur, so pulses are at least 4 cycles apart).
- Idle cycles (inbound_valid=0) freeze all state; pulses still last exactly one cycle.

Optional Feature:
- Macro NODE_DECODER_STATS_EN.
- Defined: line_cnt increments on each src pulse and edge_cnt on each edge pulse. Both saturate at all-ones, reset to 0, and are stable once done.
- Undefined: the counter ports and logic are absent.

Decomposition:
- Package aoc_node_pkg holds:
  - node_str_t (15-bit);
  - constants A_CHAR=8'h61, COLON=8'h3A, SPACE=8'h20, LF=8'h0A, CR=8'h0D, NUL=8'h00;
  - function node_str_from_node_ascii;
  - the FSM state enum.
- node_id_mapper imports the same package.
- Single module; no sub-module is warranted.

Test Plan:
- "aaa: you hhh\nNUL" -> src pulse with 15'h0000, then edges dst=15'h51D8 ("you"), then dst=15'h1CE7 ("hhh"); done=1 one cycle after NUL; parse_error=0.
- Same stream with inbound_valid toggled randomly and CR before each LF -> identical pulse sequence and values.
- "you: out\nbbb: you\nNUL" -> src 15'h51D8, edge 15'h4E8E, src 15'h0421, edge 15'h51D8; with stats, line_cnt=2 and edge_cnt=2.
- "ab: ccc\nddd: eee\nNUL" -> parse_error=1; no pulses for line 1; line 2 yields src 15'h0C63 and edge 15'h1084.
- rst_n low for 1 cycle after "aaa: bb" -> outputs cleared, no edge pulse; then "ccc: ddd\nNUL" decodes normally.
- Bytes after NUL ("zzz: yyy\n") -> no pulses; decoding_done_str stays 1.
